// File: rtl/sobel_binarize.sv
// sobel_binarize: binarizes sobel edge magnitudes against a per-frame adaptive threshold
module sobel_binarize #(
  parameter int PIX_W       = 20,
  parameter int THRESH_INIT = 64,
  parameter int OFFSET      = 16,
  parameter int ADAPTIVE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sobel_valid,
  input  logic [7:0]       sobel_data,
  input  logic             hsync,
  input  logic             vsync,
  output logic             bin_valid,
  output logic [7:0]       bin_data,
  output logic             bin_hsync,
  output logic             bin_vsync,
  output logic [7:0]       thresh,
  output logic [PIX_W-1:0] edge_count,
  output logic             stat_sat,
  output logic             div_abort
);
  localparam int SW = 8 + PIX_W;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_vs_d;
  logic [7:0]       r_pending, r_q;
  logic [SW-1:0]    r_sum, r_rem, w_sh;
  logic [PIX_W-1:0] r_cnt, r_edge, r_dcnt;
  logic [2:0]       r_k;
  logic [8:0]       w_add;
  logic             w_fs, w_edge, w_full;
  logic [7:0]       w_thr;
  assign w_fs   = r_vs_d & ~vsync;
  assign w_thr  = (ADAPTIVE != 0 && w_fs) ? r_pending : thresh;
  assign w_edge = sobel_valid && sobel_data >= w_thr;
  assign w_full = &r_cnt;
  assign w_sh   = SW'(r_dcnt) << r_k;
  assign w_add  = {1'b0, r_q} + 9'(OFFSET);
  // one-cycle pixel pipeline and vsync edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d    <= 1'b1;
      bin_valid <= 1'b0;
      bin_data  <= 8'h00;
      bin_hsync <= 1'b1;
      bin_vsync <= 1'b1;
    end else begin
      r_vs_d    <= vsync;
      bin_valid <= sobel_valid;
      bin_data  <= w_edge ? 8'hff : 8'h00;
      bin_hsync <= hsync;
      bin_vsync <= vsync;
    end
  end
  // per-frame accumulators; a pixel in the frame-start cycle seeds the new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_cnt      <= '0;
      r_edge     <= '0;
      edge_count <= '0;
      stat_sat   <= 1'b0;
      thresh     <= 8'(THRESH_INIT);
    end else if (w_fs) begin
      r_sum      <= sobel_valid ? SW'(sobel_data) : '0;
      r_cnt      <= PIX_W'(sobel_valid);
      r_edge     <= PIX_W'(w_edge);
      edge_count <= r_edge;
      if (ADAPTIVE != 0) thresh <= r_pending;
    end else if (sobel_valid) begin
      if (w_full) stat_sat <= 1'b1;
      else begin
        r_sum  <= r_sum + SW'(sobel_data);
        r_cnt  <= r_cnt + 1'b1;
        r_edge <= r_edge + PIX_W'(w_edge);
      end
    end
  end
  // divider state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // frame start always (re)launches; otherwise DIV runs 8 steps then DONE
  always_comb begin
    w_next = IDLE;
    w_next = w_fs ? (|r_cnt ? DIV : IDLE) : (r_state == DIV) ? (r_k == 3'd0 ? DONE : DIV) : IDLE;
  end
  // restoring division of sum by count, then saturating offset into pending threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= '0;
      r_dcnt    <= '0;
      r_q       <= 8'h00;
      r_k       <= 3'd0;
      r_pending <= 8'(THRESH_INIT);
      div_abort <= 1'b0;
    end else if (w_fs) begin
      r_rem  <= r_sum;
      r_dcnt <= r_cnt;
      r_q    <= 8'h00;
      r_k    <= 3'd7;
      if (r_state != IDLE) div_abort <= 1'b1;
    end else if (r_state == DIV) begin
      if (r_rem >= w_sh) begin
        r_rem    <= r_rem - w_sh;
        r_q[r_k] <= 1'b1;
      end
      r_k <= r_k - 3'd1;
    end else if (r_state == DONE) begin
      r_pending <= w_add[8] ? 8'hff : w_add[7:0];
    end
  end
endmodule

// File: tb/tb_sobel_binarize.sv
// tb_sobel_binarize: directed checks of binarization, adaptive threshold, divider abort and saturation
module tb_sobel_binarize;
  logic clk = 1'b0, rst = 1'b1, sv = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [7:0] sd = 8'd0;
  logic bin_valid, bin_hsync, bin_vsync, stat_sat, div_abort;
  logic [7:0] bin_data, thresh;
  logic [19:0] edge_count;
  logic s_valid, s_hsync, s_vsync, s_sat, s_abort;
  logic [7:0] s_data, s_thresh;
  logic [3:0] s_ec;
  logic f_valid, f_hsync, f_vsync, f_sat, f_abort;
  logic [7:0] f_data, f_thresh;
  logic [3:0] f_ec;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  sobel_binarize u_dut (
    .clk(clk), .rst(rst), .sobel_valid(sv), .sobel_data(sd), .hsync(hs), .vsync(vs),
    .bin_valid(bin_valid), .bin_data(bin_data), .bin_hsync(bin_hsync), .bin_vsync(bin_vsync),
    .thresh(thresh), .edge_count(edge_count), .stat_sat(stat_sat), .div_abort(div_abort)
  );
  sobel_binarize #(.PIX_W(4)) u_sat (
    .clk(clk), .rst(rst), .sobel_valid(sv), .sobel_data(sd), .hsync(hs), .vsync(vs),
    .bin_valid(s_valid), .bin_data(s_data), .bin_hsync(s_hsync), .bin_vsync(s_vsync),
    .thresh(s_thresh), .edge_count(s_ec), .stat_sat(s_sat), .div_abort(s_abort)
  );
  sobel_binarize #(.PIX_W(4), .ADAPTIVE(0)) u_fix (
    .clk(clk), .rst(rst), .sobel_valid(sv), .sobel_data(sd), .hsync(hs), .vsync(vs),
    .bin_valid(f_valid), .bin_data(f_data), .bin_hsync(f_hsync), .bin_vsync(f_vsync),
    .thresh(f_thresh), .edge_count(f_ec), .stat_sat(f_sat), .div_abort(f_abort)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic h, input logic y);
    sv = v; sd = d; hs = h; vs = y;
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [7:0] d, input logic [7:0] e);
    cyc(1'b1, d, 1'b0, 1'b1);
    chk("pix_valid", bin_valid, 1);
    chk("pix_hsync", bin_hsync, 0);
    chk("pix_data", bin_data, e);
  endtask
  task automatic blank(input int n);
    repeat (n) cyc(1'b0, 8'd0, 1'b1, 1'b1);
  endtask
  task automatic vs_pulse(input logic [7:0] et, input logic [19:0] ec);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("frame_thresh", thresh, et);
    chk("frame_edge_count", edge_count, ec);
    chk("bin_vsync", bin_vsync, 0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 8'd200, 1'b1, 1'b1);
      chk("rst_valid", bin_valid, 0);
      chk("rst_thresh", thresh, 64);
      chk("rst_edge_count", edge_count, 0);
    end
    chk("rst_stat_sat", stat_sat, 0);
    chk("rst_div_abort", div_abort, 0);
    rst = 1'b0;
    pix(8'd10, 8'd0);
    blank(3);
    vs_pulse(8'd64, 20'd0);
    repeat (16) pix(8'd100, 8'd255);
    blank(10);
    vs_pulse(8'd26, 20'd16);
    repeat (16) pix(8'd100, 8'd255);
    blank(10);
    vs_pulse(8'd116, 20'd16);
    repeat (16) pix(8'd100, 8'd0);
    blank(10);
    vs_pulse(8'd116, 20'd0);
    pix(8'd200, 8'd255);
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    chk("lat_valid_off", bin_valid, 0);
    chk("lat_hsync_off", bin_hsync, 1);
    blank(10);
    vs_pulse(8'd116, 20'd1);
    repeat (16) pix(8'd250, 8'd255);
    blank(10);
    vs_pulse(8'd216, 20'd16);
    blank(10);
    vs_pulse(8'd255, 20'd0);
    pix(8'd254, 8'd0);
    pix(8'd255, 8'd255);
    blank(10);
    vs_pulse(8'd255, 20'd1);
    repeat (16) pix(8'd32, 8'd0);
    blank(10);
    vs_pulse(8'd255, 20'd0);
    pix(8'd80, 8'd0);
    blank(1);
    chk("abort_before", div_abort, 0);
    vs_pulse(8'd255, 20'd0);
    chk("abort_after", div_abort, 1);
    repeat (4) pix(8'd40, 8'd0);
    blank(10);
    vs_pulse(8'd96, 20'd0);
    pix(8'd96, 8'd255);
    pix(8'd95, 8'd0);
    blank(10);
    vs_pulse(8'd56, 20'd1);
    pix(8'd56, 8'd255);
    pix(8'd55, 8'd0);
    blank(10);
    chk("fixed_thresh_mid", f_thresh, 64);
    chk("small_sat_early", s_sat, 1);
    rst = 1'b1;
    blank(2);
    chk("rst2_small_sat", s_sat, 0);
    chk("rst2_stat_sat", stat_sat, 0);
    chk("rst2_div_abort", div_abort, 0);
    rst = 1'b0;
    blank(2);
    vs_pulse(8'd64, 20'd0);
    repeat (15) pix(8'd100, 8'd255);
    repeat (5) pix(8'd255, 8'd255);
    chk("sat_small", s_sat, 1);
    chk("sat_main", stat_sat, 0);
    blank(10);
    vs_pulse(8'd64, 20'd20);
    chk("sat_small_ec", s_ec, 15);
    chk("sat_fixed_ec", f_ec, 15);
    blank(10);
    vs_pulse(8'd154, 20'd0);
    chk("sat_small_thresh", s_thresh, 116);
    chk("fixed_thresh_end", f_thresh, 64);
    chk("fixed_sat", f_sat, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
